alu_mul_seq: RTL and testbench
==============================

// Module: alu_mul_seq
// PURPOSE
//   Iterative, parametrised radix-4 Booth multiplier for the ALU datapath. It produces a full
//   2*WIDTH-bit product and supports signed or unsigned operands. It retires one Booth bit-pair
//   per clock behind a start/done handshake. It serves the mul instruction in the multi-cycle
//   control path and frees the combinational multiplier's timing budget.
// PARAMETERS
//   WIDTH  32  operand width in bits; must be even and >= 4.
//   ITER   WIDTH/2+1  derived localparam, not overridable: number of bit-pair iterations.
// PORTS
//   clk        in   1        single clock, rising edge
//   clr_n      in   1        asynchronous active-low reset
//   start      in   1        request: capture A, B and is_signed on this edge
//   is_signed  in   1        1 = two's-complement operands, 0 = unsigned operands
//   A          in   WIDTH    multiplicand
//   B          in   WIDTH    multiplier
//   busy       out  1        iteration in progress
//   done       out  1        one-cycle pulse: P is valid
//   P          out  2*WIDTH  product; held until the next accepted start
// BEHAVIOUR
//   - Reset (clr_n=0, asynchronous): state IDLE; busy=0, done=0, P=0; accumulator cleared.
//   - States and transitions:
//     - IDLE: start=1 -> RUN.
//     - RUN: counter reaches ITER -> DONE.
//     - DONE: start=1 -> RUN; start=0 -> IDLE.
//   - Accepting start: start is honoured only in IDLE or DONE. start while busy is ignored;
//     the operands are not re-sampled.
//   - Load (edge t with start accepted):
//     - Mcand = A extended to WIDTH+2 bits: sign extension if is_signed, else zero extension.
//     - Mplier = {ext2(B), 1'b0}: the two extension bits are sign or zero, as for A.
//     - Accumulator (2*WIDTH+2 bits) = 0; counter = 0; busy=1.
//   - Each RUN cycle:
//     - Recode the low 3 bits of Mplier: 000/111 -> 0; 001/010 -> +M; 011 -> +2M;
//       100 -> -2M; 101/110 -> -M.
//     - The partial product is sign-extended to the accumulator width and shifted left by
//       2*counter, then added.
//     - Mplier is shifted right arithmetically by 2; counter increments.
//   - Latency: edges t+1..t+ITER perform the iterations. After edge t+ITER:
//     - state DONE, done=1 for exactly one cycle, busy=0.
//     - P = accumulator[2*WIDTH-1:0], registered on that same edge.
//     - Start-to-done is 17 cycles for WIDTH=32.
//   - Arithmetic:
//     - The product is exact for both modes; there is no overflow flag.
//     - Accumulator upper 2 bits are discarded.
//     - Unsigned mode is correct for all operand values through the zero-extended final pair.
//   - Back-to-back: start in the DONE cycle reloads the operands. done drops and busy rises on
//     the next edge, and P keeps its old value until the new done.
//   - Reset mid-operation: immediate return to IDLE. P=0, done is not asserted, and the partial
//     result is lost.
// CONFIGURATION
//   - ALU_MUL_SEQ_EARLY_EXIT_EN defined:
//     - Before each iteration, check whether the remaining Mplier bits (including the overlap
//       bit) are all 0 or all 1. If they are, go RUN -> DONE on that edge without adding.
//     - Latency is 1..ITER cycles.
//     - done and P timing relative to the final state is otherwise unchanged.
//   - Not defined: latency is always exactly ITER cycles. No all-equal detector is synthesised.
// STRUCTURE
//   - Package alu_mul_pkg:
//     - state typedef {IDLE, RUN, DONE}.
//     - Booth recode typedef {ZERO, POS1, POS2, NEG1, NEG2}.
//     - function iter_count(WIDTH).
//   - Sub-module booth_r4_select: combinational. Maps a 3-bit group and Mcand to the
//     sign-extended partial product (0, +-M, +-2M), using the two's-complement negate.
//   - Top level holds the FSM, counter, shift registers, accumulator and P register.
// TESTING
//   - Signed, A=-7, B=3 -> P=64'hFFFF_FFFF_FFFF_FFEB; done pulses exactly 17 cycles after start.
//   - Unsigned, A=B=32'hFFFF_FFFF -> P=64'hFFFF_FFFE_0000_0001. The same operands signed -> P=1.
//   - Signed, A=B=32'h8000_0000 -> P=64'h4000_0000_0000_0000.
//   - start re-pulsed with A=5, B=5 at cycle 4 of a 6*7 job -> ignored; P=42; one done pulse.
//   - clr_n low at cycle 8 of a job, then a new job 2*3 -> P=0 during reset, no done, then P=6.
//   - EARLY_EXIT_EN, signed, A=9, B=3 -> done 2 cycles after start, P=27. Without the macro:
//     17 cycles, P=27.

Source files
------------

// File: rtl/alu_mul_pkg.sv
// Shared types and helpers for the iterative radix-4 Booth multiplier.
// The early-exit option is selected with ALU_MUL_SEQ_EARLY_EXIT_EN in alu_mul_seq.sv.
package alu_mul_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} booth_t;

   // One iteration per bit-pair, plus one for the extension pair.
   function automatic int iter_count(input int width);
      return width / 2 + 1;
   endfunction

   function automatic booth_t booth_recode(input logic [2:0] grp);
      case (grp)
         3'b001, 3'b010: return POS1;
         3'b011:         return POS2;
         3'b100:         return NEG2;
         3'b101, 3'b110: return NEG1;
         default:        return ZERO;
      endcase
   endfunction

endpackage

// File: rtl/booth_r4_select.sv
// Radix-4 Booth partial-product selector: maps a 3-bit multiplier group and the
// extended multiplicand to a sign-extended 0, +-M or +-2M at accumulator width.
module booth_r4_select
   import alu_mul_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]         grp,
   input  logic [WIDTH+1:0]   mcand,
   output logic [2*WIDTH+1:0] pp
);

   localparam int AW = 2 * WIDTH + 2;

   logic [AW-1:0] m1;
   logic [AW-1:0] m2;

   assign m1 = {{WIDTH{mcand[WIDTH+1]}}, mcand};
   assign m2 = m1 << 1;

   always_comb begin
      // NOTE: default assignment first so no path through the case infers a latch.
      pp = '0;
      case (booth_recode(grp))
         POS1:    pp = m1;
         POS2:    pp = m2;
         NEG1:    pp = ~m1 + AW'(1);
         NEG2:    pp = ~m2 + AW'(1);
         default: pp = '0;
      endcase
   end

endmodule

// File: rtl/alu_mul_seq.sv
// Iterative radix-4 Booth multiplier, one bit-pair per clock behind start/done.
// Define ALU_MUL_SEQ_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are all equal.
module alu_mul_seq
   import alu_mul_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               clr_n,
   input  logic               start,
   input  logic               is_signed,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] P
);

   localparam int ITER = iter_count(WIDTH);
   localparam int MW   = WIDTH + 2;
   localparam int RW   = WIDTH + 3;
   localparam int AW   = 2 * WIDTH + 2;
   localparam int CW   = $clog2(ITER);

   state_t        state;
   state_t        state_nxt;
   logic [MW-1:0] mcand;
   logic [RW-1:0] mplier;
   logic [RW-1:0] mplier_sh;
   logic [AW-1:0] acc;
   logic [AW-1:0] acc_nxt;
   logic [AW-1:0] pp;
   logic [CW-1:0] cnt;
   logic          accept;
   logic          last;

   booth_r4_select #(.WIDTH(WIDTH)) u_select (
      .grp   (mplier[2:0]),
      .mcand (mcand),
      .pp    (pp)
   );

   assign accept    = start && (state != RUN);
   assign acc_nxt   = acc + (pp << {cnt, 1'b0});
   assign mplier_sh = {{2{mplier[RW-1]}}, mplier[RW-1:2]};

`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
   // Once the shifted multiplier is all 0s or all 1s, every later group recodes to zero.
   assign last = (cnt == CW'(ITER - 1)) || (&mplier_sh) || (~|mplier_sh);
`else
   assign last = (cnt == CW'(ITER - 1));
`endif

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = DONE;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   // NOTE: the datapath is reset as well, so P reads 0 after clr_n and no X reaches the adder.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
         P      <= '0;
      end else if (accept) begin
         mcand  <= {{2{is_signed & A[WIDTH-1]}}, A};
         mplier <= {{2{is_signed & B[WIDTH-1]}}, B, 1'b0};
         acc    <= '0;
         cnt    <= '0;
      end else if (state == RUN) begin
         acc    <= acc_nxt;
         mplier <= mplier_sh;
         cnt    <= cnt + CW'(1);
         if (last) P <= acc_nxt[2*WIDTH-1:0];
      end
   end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq: a driver queues reference products, a monitor
// checks P, latency, done/busy and P hold behaviour on every falling edge.
module tb_alu_mul_seq;

`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
   localparam int          LAT    = 0;
   localparam int          LAT_93 = 2;
   localparam logic [31:0] IGN_B  = 32'h4000_0007;
`else
   localparam int          LAT    = 17;
   localparam int          LAT_93 = 17;
   localparam logic [31:0] IGN_B  = 32'h0000_0007;
`endif

   typedef struct {
      logic [63:0] p;
      int          t;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        clr_n;
   logic        start;
   logic        is_signed;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic        done;
   logic [63:0] P;

   exp_t        exp_q[$];
   logic [63:0] p_model = '0;
   int          cyc = 0;
   int          vectors = 0;
   int          miscompares = 0;

   alu_mul_seq #(.WIDTH(32)) dut (
      .clk       (clk),
      .clr_n     (clr_n),
      .start     (start),
      .is_signed (is_signed),
      .A         (A),
      .B         (B),
      .busy      (busy),
      .done      (done),
      .P         (P)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
      longint          sa;
      longint          sb;
      longint unsigned ua;
      longint unsigned ub;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return 64'(sa * sb);
      end
      ua = {32'h0, a};
      ub = {32'h0, b};
      return ua * ub;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (done) begin
         check("busy_in_done", 64'(busy), 64'd0);
         if (exp_q.size() == 0) begin
            check("done_spurious", 64'(done), 64'd0);
         end else begin
            check("product", P, exp_q[0].p);
            if (exp_q[0].lat != 0)
               check("latency", 64'(cyc - exp_q[0].t), 64'(exp_q[0].lat));
            else
               check("latency_range", 64'((cyc - exp_q[0].t) >= 1 && (cyc - exp_q[0].t) <= 17), 64'd1);
            p_model = exp_q[0].p;
            void'(exp_q.pop_front());
         end
      end else begin
         check("p_hold", P, p_model);
         if (exp_q.size() != 0 && (cyc - exp_q[0].t) >= 17)
            check("done_missing", 64'(done), 64'd1);
         if (!clr_n) check("busy_in_reset", 64'(busy), 64'd0);
      end
   end

   // Called at a falling edge; start is captured on the next rising edge.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input int lat);
      start     = 1'b1;
      A         = a;
      B         = b;
      is_signed = s;
      exp_q.push_back('{ref_mul(a, b, s), cyc + 1, lat});
      @(negedge clk);
      start     = 1'b0;
      A         = $urandom;
      B         = $urandom;
      is_signed = 1'($urandom);
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         check("drain_timeout", 64'(exp_q.size()), 64'd0);
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   task automatic wait_done();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 40);
      if (!done) check("done_wait_timeout", 64'(done), 64'd1);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'h0000_0001;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      clr_n     = 1'b0;
      start     = 1'b0;
      is_signed = 1'b0;
      A         = '0;
      B         = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_p", P, 64'd0);
      @(posedge clk);
      #2 clr_n = 1'b1;
      @(negedge clk);

      issue(32'hFFFF_FFF9, 32'd3, 1'b1, LAT);
      drain();
      check("neg7x3_value", p_model, 64'hFFFF_FFFF_FFFF_FFEB);
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, LAT);
      wait_done();
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, LAT);
      wait_done();
      issue(32'h8000_0000, 32'h8000_0000, 1'b1, LAT);
      drain();
      check("min_sq_value", p_model, 64'h4000_0000_0000_0000);
      issue(32'd9, 32'd3, 1'b1, LAT_93);
      drain();

      // A second start while busy must not disturb the running job.
      issue(32'd6, IGN_B, 1'b0, LAT);
      repeat (2) @(negedge clk);
      start = 1'b1;
      A     = 32'd5;
      B     = 32'd5;
      @(negedge clk);
      start = 1'b0;
      drain();

      // Reset mid-job: result lost, P cleared, no done, then a fresh job.
      issue(32'd6, IGN_B, 1'b0, LAT);
      repeat (6) @(negedge clk);
      @(posedge clk);
      #2 clr_n = 1'b0;
      exp_q.delete();
      p_model = '0;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 clr_n = 1'b1;
      @(negedge clk);
      issue(32'd2, 32'd3, 1'b0, LAT);
      drain();
      check("after_reset_value", p_model, 64'd6);

      for (int j = 0; j < 40; j++) begin
         if (exp_q.size() != 0 && $urandom_range(0, 1) == 1) begin
            wait_done();
         end else begin
            drain();
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end
         issue(pick_operand(), pick_operand(), 1'($urandom), LAT);
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
